// File: rtl/jk_vector_reg.sv
// WIDTH-bit register with per-bit JK update plus count-up, count-down and parallel-load modes.
// Define JK_SAT_EN to make the counters saturate instead of wrapping.
module jk_vector_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             chg
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_LD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;
    logic             at_max, at_min;

    assign at_max = (q_q == {WIDTH{1'b1}});
    assign at_min = (q_q == {WIDTH{1'b0}});

    // Next-state selection; en=0 leaves q_d == q_q so chg falls to 0.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
`ifdef JK_SAT_EN
                MODE_UP: q_d = at_max ? q_q : q_q + WIDTH'(1);
                MODE_DN: q_d = at_min ? q_q : q_q - WIDTH'(1);
`else
                MODE_UP: q_d = q_q + WIDTH'(1);
                MODE_DN: q_d = q_q - WIDTH'(1);
`endif
                MODE_LD: q_d = d;
                default: q_d = q_q;
            endcase
        end
        chg_d = (q_d != q_q);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            q_q   <= RESET_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign chg  = chg_q;
    assign tc   = en & ~RESET & (((mode == MODE_UP) & at_max) | ((mode == MODE_DN) & at_min));

endmodule

// File: tb/tb_jk_vector_reg.sv
// Directed self-checking bench for jk_vector_reg at WIDTH=4, RESET_VAL=0.
module tb_jk_vector_reg;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             RESET;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j, k, d;
    logic [WIDTH-1:0] q, qbar;
    logic             tc, chg;

    int n_checks = 0;
    int n_pass   = 0;

    jk_vector_reg #(.WIDTH(WIDTH), .RESET_VAL(4'h0)) dut (
        .clk  (clk),
        .RESET(RESET),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .q    (q),
        .qbar (qbar),
        .tc   (tc),
        .chg  (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        RESET = 1'b1; en = 1'b1; mode = 2'b01; j = '0; k = '0; d = '0;
        #1;

        // 1: reset then count up once
        step(); step();
        check("rst_q",    32'(q),    32'h0);
        check("rst_qbar", 32'(qbar), 32'hF);
        check("rst_chg",  32'(chg),  32'h0);
        check("rst_tc",   32'(tc),   32'h0);
        RESET = 1'b0;
        step();
        check("up1_q",   32'(q),   32'h1);
        check("up1_chg", 32'(chg), 32'h1);

        // 2: load, JK update, JK hold, equal load
        mode = 2'b11; d = 4'hA;
        step();
        check("ldA_q",   32'(q),   32'hA);
        check("ldA_chg", 32'(chg), 32'h1);
        mode = 2'b00; j = 4'b0011; k = 4'b0101;
        step();
        check("jk_q",    32'(q),    32'hB);
        check("jk_qbar", 32'(qbar), 32'h4);
        check("jk_chg",  32'(chg),  32'h1);
        j = 4'b0000; k = 4'b0000;
        settle();
        check("jk_tc", 32'(tc), 32'h0);
        step();
        check("hold_q",   32'(q),   32'hB);
        check("hold_chg", 32'(chg), 32'h0);
        mode = 2'b11; d = 4'hB;
        step();
        check("ldeq_q",   32'(q),   32'hB);
        check("ldeq_chg", 32'(chg), 32'h0);

        // 3: count up through all-ones
        d = 4'hE;
        step();
        mode = 2'b01;
        step();
        check("upF_q", 32'(q), 32'hF);
        settle();
        check("upF_tc", 32'(tc), 32'h1);
        step();
`ifdef JK_SAT_EN
        check("wrapup_q",   32'(q),   32'hF);
        check("wrapup_chg", 32'(chg), 32'h0);
        check("wrapup_tc",  32'(tc),  32'h1);
`else
        check("wrapup_q",   32'(q),   32'h0);
        check("wrapup_chg", 32'(chg), 32'h1);
        check("wrapup_tc",  32'(tc),  32'h0);
`endif

        // 4: count down through zero
        mode = 2'b11; d = 4'h1;
        settle();
        check("ld_tc", 32'(tc), 32'h0);
        step();
        mode = 2'b10;
        step();
        check("dn0_q", 32'(q), 32'h0);
        settle();
        check("dn0_tc", 32'(tc), 32'h1);
        step();
`ifdef JK_SAT_EN
        check("wrapdn_q",   32'(q),   32'h0);
        check("wrapdn_chg", 32'(chg), 32'h0);
`else
        check("wrapdn_q",   32'(q),   32'hF);
        check("wrapdn_chg", 32'(chg), 32'h1);
`endif
        mode = 2'b00;
        settle();
        check("jkmode_tc", 32'(tc), 32'h0);

        // 5: en=0 holds
        mode = 2'b11; d = 4'h6;
        step();
        mode = 2'b01; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("en0_tc", 32'(tc), 32'h0);
            step();
            check("en0_q",   32'(q),   32'h6);
            check("en0_chg", 32'(chg), 32'h0);
        end
        en = 1'b1;
        step();
        check("en1_q",   32'(q),   32'h7);
        check("en1_chg", 32'(chg), 32'h1);

        // 6: reset overrides load
        RESET = 1'b1; mode = 2'b11; d = 4'h5;
        settle();
        check("rstld_tc", 32'(tc), 32'h0);
        step();
        check("rstld_q",    32'(q),    32'h0);
        check("rstld_qbar", 32'(qbar), 32'hF);
        check("rstld_chg",  32'(chg),  32'h0);
        RESET = 1'b0;
        step();
        check("ld5_q",   32'(q),   32'h5);
        check("ld5_chg", 32'(chg), 32'h1);

        // Full toggle and d ignored outside load mode
        mode = 2'b00; j = 4'hF; k = 4'hF; d = 4'h3;
        step();
        check("tog_q", 32'(q), 32'hA);
        mode = 2'b10; j = 4'h0; k = 4'hF;
        step();
        check("dn9_q", 32'(q), 32'h9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
